rc4_prga_gen: RTL and testbench
===============================

# rc4_prga_gen

Parametrised RC4 pseudo-random generation stage, the successor to the fixed 256-entry PRGA. It runs after key scheduling has filled S-memory and streams keystream bytes into plaintext memory. It adds a configurable S-box size (`AW`), an RC4-drop[n] discard phase (`DROP`), and a run-time mode. In decrypt mode it writes `pt = ct ^ pad`; in keystream mode it writes the raw pad.

## Interface
Parameters:
- `AW`, default 8: S-box address/data width, N = 2^AW entries; legal range 4..8.
- `DROP`, default 0: keystream bytes generated and discarded before the first output byte; legal range 0..1024.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `en` in 1: start request, accepted only when `rdy`=1.
- `mode` in 1: 0 = decrypt (`pt = ct ^ pad`), 1 = keystream (`pt = pad`, ct bytes unused); sampled when `en` is accepted.
- `rdy` out 1: high only in IDLE.
- `done` out 1: one-cycle pulse when a run completes.
- `s_addr` out AW, `s_wrdata` out AW, `s_wren` out 1, `s_rddata` in AW: S-memory port, single-port, synchronous read.
- `ct_addr` out 8, `ct_rddata` in 8: ciphertext memory, synchronous read; `ct[0]` holds the length.
- `pt_addr` out 8, `pt_wrdata` out 8, `pt_wren` out 1: plaintext memory write port.

## Operation
- All memories have 1-cycle read latency: an address presented in cycle t gives valid data in cycle t+1.
- Registers:
  - `i`, `j`: AW bits, cleared at start.
  - `k`: 8 bits, output index, starts at 1.
  - `len`: 8 bits.
  - `drop_cnt`: 11 bits, loaded with `DROP` at start.
  - `si`, `sj`: AW bits.
  - `mode_q`.
- All i/j/pad-index arithmetic is modulo N, truncated to AW bits.
- `pad` is zero-extended to 8 bits before the XOR.
- States and transitions:
  - IDLE: `rdy`=1. On `en` → LEN_RD.
  - LEN_RD: `ct_addr`=0.
  - LEN_WT: `len`←`ct_rddata`; `pt_addr`=0, `pt_wrdata`=`len`, `pt_wren`=1. Go to DONE if `len`=0 and `drop_cnt`=0, else SI_RD.
  - SI_RD: `i`←`i`+1; `s_addr`=`i`+1.
  - SI_WT: `si`←`s_rddata`; `j`←`j`+`s_rddata`; `s_addr`=`j`+`s_rddata`.
  - SJ_WT: `sj`←`s_rddata`; write `S[j]`=`si`.
  - SWP_I: write `S[i]`=`sj`.
  - K_RD: `s_addr`=`si`+`sj`; `ct_addr`=`k`.
  - K_WT, if `drop_cnt`≠0: `drop_cnt`−1, no pt write.
  - K_WT, otherwise: write `pt[k]` = `mode_q` ? pad : (`ct_rddata` ^ pad), then `k`+1.
  - K_WT exit: go to DONE when the byte just written has `k`=`len` (or `len`=0 and the drop has finished); else SI_RD.
  - DONE: `done`=1 for one cycle, then IDLE.
- The case `i`=`j` needs no special handling: both writes store `si`.
- `i` wraps N−1→0 with no special handling; `len` up to 255 is independent of N.
- `en` outside IDLE is ignored and has no effect.
- `mode` changes mid-run have no effect.
- `ct_addr`, `s_addr` and `pt_addr` hold their last value when unused; only the write enables are qualified.

## Timing
- With `rst` high at an edge, the next cycle has state=IDLE and all registers cleared.
- During and after reset: `s_wren`=`pt_wren`=0 and `done`=0. `rdy`=0 while `rst` is asserted and 1 in the first cycle after deassertion.
- Reset mid-run aborts immediately; no further memory writes occur.
- Per keystream byte: 6 cycles (SI_RD..K_WT).
- From `en` acceptance edge to `done` high: 2 + 6·(DROP+len) cycles.
- `rdy` returns the cycle after `done`.
- A new `en` may be accepted in that same cycle.
- At most one write (S or pt) is issued per cycle.
- S is left in its post-run permuted state; it is not restored.

## Structure
- Package `rc4_pkg`:
  - state enum `prga_state_t`.
  - `PRGA_MODE_DECRYPT`=0, `PRGA_MODE_KEYSTREAM`=1.
  - `LEN_ADDR`=8'h00.
- Single module, no sub-module; the swap/index datapath is too small to split.

## Test plan
- Identity S (`S[x]`=x), AW=8, `mode`=1, `ct[0]`=2 → `pt[0]`=02, `pt[1]`=02, `pt[2]`=05; `done` exactly 14 cycles after `en` accepted; `S[2]`=03, `S[3]`=02.
- Same S, `mode`=0, `ct`={02,FF,0F} → `pt[1]`=FD, `pt[2]`=0A.
- `DROP`=1, identity S, `mode`=1, `ct[0]`=1 → `pt[1]`=05, no pt write during the dropped byte, `done` after 14 cycles.
- AW=4, identity 16-entry S, `mode`=1, `ct[0]`=20 → `i` wraps 15→0 and all 20 pads match the modulo-16 reference model; `pt_wrdata[7:4]`=0.
- `ct[0]`=0, DROP=0 → single `pt[0]`=00 write, `done` 2 cycles after `en`, S untouched.
- Assert `rst` during SJ_WT → no further `s_wren`/`pt_wren`, `rdy`=1 the cycle after release; `en` pulsed while busy in a separate run is ignored.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the parametrised RC4 keystream generator.
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_RD,
        ST_LEN_WT,
        ST_SI_RD,
        ST_SI_WT,
        ST_SJ_WT,
        ST_SWP_I,
        ST_K_RD,
        ST_K_WT,
        ST_DONE
    } prga_state_t;

    localparam logic       PRGA_MODE_DECRYPT   = 1'b0;
    localparam logic       PRGA_MODE_KEYSTREAM = 1'b1;
    localparam logic [7:0] LEN_ADDR            = 8'h00;

endpackage

// File: rtl/rc4_prga_gen.sv
// RC4 pseudo-random generation stage with configurable S-box width, drop[n]
// discard phase and decrypt/keystream output modes.
module rc4_prga_gen
    import rc4_pkg::*;
#(
    parameter int AW   = 8,
    parameter int DROP = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          mode,
    output logic          rdy,
    output logic          done,
    output logic [AW-1:0] s_addr,
    output logic [AW-1:0] s_wrdata,
    output logic          s_wren,
    input  logic [AW-1:0] s_rddata,
    output logic [7:0]    ct_addr,
    input  logic [7:0]    ct_rddata,
    output logic [7:0]    pt_addr,
    output logic [7:0]    pt_wrdata,
    output logic          pt_wren
);

    localparam logic [AW-1:0] ONE = AW'(1);

    prga_state_t   state;
    logic [AW-1:0] i, j, si, sj;
    logic [7:0]    k, len;
    logic [10:0]   drop_cnt;
    logic          mode_q;
    logic [AW-1:0] s_addr_q;
    logic [7:0]    ct_addr_q, pt_addr_q;

    logic [7:0] pad;
    logic       drop_active, last_byte;

    assign pad         = 8'(s_rddata);
    assign drop_active = (drop_cnt != 11'd0);
    // A zero-length run with a drop phase ends on the last discarded byte.
    assign last_byte   = drop_active ? ((drop_cnt == 11'd1) && (len == 8'd0))
                                     : (k == len);

    assign rdy  = (state == ST_IDLE) && !rst;
    assign done = (state == ST_DONE) && !rst;

    always_comb begin
        s_addr    = s_addr_q;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        ct_addr   = ct_addr_q;
        pt_addr   = pt_addr_q;
        pt_wrdata = '0;
        pt_wren   = 1'b0;
        case (state)
            ST_LEN_RD: ct_addr = LEN_ADDR;
            ST_LEN_WT: begin
                pt_addr   = LEN_ADDR;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
            end
            ST_SI_RD: s_addr = i + ONE;
            ST_SI_WT: s_addr = j + s_rddata;
            ST_SJ_WT: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
            end
            ST_SWP_I: begin
                s_addr   = i;
                s_wrdata = sj;
                s_wren   = 1'b1;
            end
            ST_K_RD: begin
                s_addr  = si + sj;
                ct_addr = k;
            end
            ST_K_WT: begin
                if (!drop_active) begin
                    pt_addr   = k;
                    pt_wrdata = (mode_q == PRGA_MODE_KEYSTREAM) ? pad : (ct_rddata ^ pad);
                    pt_wren   = 1'b1;
                end
            end
            default: ;
        endcase
        // Reset aborts at once: no write may land in the cycle it is raised.
        if (rst) begin
            s_wren  = 1'b0;
            pt_wren = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            i         <= '0;
            j         <= '0;
            si        <= '0;
            sj        <= '0;
            k         <= '0;
            len       <= '0;
            drop_cnt  <= '0;
            mode_q    <= 1'b0;
            s_addr_q  <= '0;
            ct_addr_q <= '0;
            pt_addr_q <= '0;
        end else begin
            s_addr_q  <= s_addr;
            ct_addr_q <= ct_addr;
            pt_addr_q <= pt_addr;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        i        <= '0;
                        j        <= '0;
                        k        <= 8'd1;
                        drop_cnt <= 11'(DROP);
                        mode_q   <= mode;
                        state    <= ST_LEN_RD;
                    end
                end
                ST_LEN_RD: state <= ST_LEN_WT;
                ST_LEN_WT: begin
                    len   <= ct_rddata;
                    state <= ((ct_rddata == 8'd0) && !drop_active) ? ST_DONE : ST_SI_RD;
                end
                ST_SI_RD: begin
                    i     <= i + ONE;
                    state <= ST_SI_WT;
                end
                ST_SI_WT: begin
                    si    <= s_rddata;
                    j     <= j + s_rddata;
                    state <= ST_SJ_WT;
                end
                ST_SJ_WT: begin
                    sj    <= s_rddata;
                    state <= ST_SWP_I;
                end
                ST_SWP_I: state <= ST_K_RD;
                ST_K_RD:  state <= ST_K_WT;
                ST_K_WT: begin
                    if (drop_active) begin
                        drop_cnt <= drop_cnt - 11'd1;
                    end else begin
                        k <= k + 8'd1;
                    end
                    state <= last_byte ? ST_DONE : ST_SI_RD;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_prga_gen.sv
// Self-checking bench for rc4_prga_gen: three configurations share one set of
// memory models, compared against a plain-arithmetic RC4 reference.
module tb_rc4_prga_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       mode;
    logic [2:0] en_v;
    int         sel;

    // Instance 0: AW=8 DROP=0, instance 1: AW=8 DROP=1, instance 2: AW=4 DROP=0
    logic       rdy0, done0, s_wren0, pt_wren0;
    logic [7:0] s_addr0, s_wrdata0, ct_addr0, pt_addr0, pt_wrdata0;
    logic       rdy1, done1, s_wren1, pt_wren1;
    logic [7:0] s_addr1, s_wrdata1, ct_addr1, pt_addr1, pt_wrdata1;
    logic       rdy2, done2, s_wren2, pt_wren2;
    logic [3:0] s_addr2, s_wrdata2;
    logic [7:0] ct_addr2, pt_addr2, pt_wrdata2;

    logic [7:0] s_rddata, ct_rddata;

    rc4_prga_gen #(.AW(8), .DROP(0)) dut0 (
        .clk(clk), .rst(rst), .en(en_v[0]), .mode(mode), .rdy(rdy0), .done(done0),
        .s_addr(s_addr0), .s_wrdata(s_wrdata0), .s_wren(s_wren0), .s_rddata(s_rddata),
        .ct_addr(ct_addr0), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr0), .pt_wrdata(pt_wrdata0), .pt_wren(pt_wren0));

    rc4_prga_gen #(.AW(8), .DROP(1)) dut1 (
        .clk(clk), .rst(rst), .en(en_v[1]), .mode(mode), .rdy(rdy1), .done(done1),
        .s_addr(s_addr1), .s_wrdata(s_wrdata1), .s_wren(s_wren1), .s_rddata(s_rddata),
        .ct_addr(ct_addr1), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr1), .pt_wrdata(pt_wrdata1), .pt_wren(pt_wren1));

    rc4_prga_gen #(.AW(4), .DROP(0)) dut2 (
        .clk(clk), .rst(rst), .en(en_v[2]), .mode(mode), .rdy(rdy2), .done(done2),
        .s_addr(s_addr2), .s_wrdata(s_wrdata2), .s_wren(s_wren2), .s_rddata(s_rddata[3:0]),
        .ct_addr(ct_addr2), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr2), .pt_wrdata(pt_wrdata2), .pt_wren(pt_wren2));

    logic [7:0] s_addr_m, s_wrdata_m, ct_addr_m, pt_addr_m, pt_wrdata_m;
    logic       s_wren_m, pt_wren_m, rdy_m, done_m;

    always_comb begin
        case (sel)
            1: begin
                s_addr_m = s_addr1; s_wrdata_m = s_wrdata1; s_wren_m = s_wren1;
                ct_addr_m = ct_addr1; pt_addr_m = pt_addr1; pt_wrdata_m = pt_wrdata1;
                pt_wren_m = pt_wren1; rdy_m = rdy1; done_m = done1;
            end
            2: begin
                s_addr_m = {4'b0, s_addr2}; s_wrdata_m = {4'b0, s_wrdata2}; s_wren_m = s_wren2;
                ct_addr_m = ct_addr2; pt_addr_m = pt_addr2; pt_wrdata_m = pt_wrdata2;
                pt_wren_m = pt_wren2; rdy_m = rdy2; done_m = done2;
            end
            default: begin
                s_addr_m = s_addr0; s_wrdata_m = s_wrdata0; s_wren_m = s_wren0;
                ct_addr_m = ct_addr0; pt_addr_m = pt_addr0; pt_wrdata_m = pt_wrdata0;
                pt_wren_m = pt_wren0; rdy_m = rdy0; done_m = done0;
            end
        endcase
    end

    logic [7:0]  smem [256];
    logic [7:0]  ctmem[256];
    logic [7:0]  ptmem[256];
    logic [15:0] ptq[$];
    int          s_wr_cnt, dual_wr;
    logic [3:0]  hi_or;

    // Memories read the old contents on a same-cycle write (read-before-write).
    always @(posedge clk) begin
        s_rddata  <= smem[s_addr_m];
        ct_rddata <= ctmem[ct_addr_m];
        if (s_wren_m) begin
            smem[s_addr_m] = s_wrdata_m;
            s_wr_cnt = s_wr_cnt + 1;
        end
        if (pt_wren_m) begin
            ptmem[pt_addr_m] = pt_wrdata_m;
            ptq.push_back({pt_addr_m, pt_wrdata_m});
            if (pt_addr_m != 8'd0) hi_or = hi_or | pt_wrdata_m[7:4];
        end
        if (s_wren_m && pt_wren_m) dual_wr = dual_wr + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int         s_ref[256];
    logic [7:0] pt_exp[256];

    // Textbook RC4 PRGA over an N-entry table, first `drop` bytes thrown away.
    task automatic refModel(input int n, input int drop, input int len, input bit m);
        int ri, rj, t, pad;
        ri = 0;
        rj = 0;
        for (int x = 0; x < 256; x++) s_ref[x] = int'(smem[x]);
        pt_exp[0] = 8'(len);
        for (int b = 0; b < drop + len; b++) begin
            ri = (ri + 1) % n;
            rj = (rj + s_ref[ri]) % n;
            t = s_ref[ri]; s_ref[ri] = s_ref[rj]; s_ref[rj] = t;
            pad = s_ref[(s_ref[ri] + s_ref[rj]) % n];
            if (b >= drop)
                pt_exp[b - drop + 1] = m ? 8'(pad) : (ctmem[b - drop + 1] ^ 8'(pad));
        end
    endtask

    task automatic fillCt();
        for (int x = 1; x < 256; x++) ctmem[x] = 8'($urandom);
    endtask

    task automatic loadS(input int n, input bit ident);
        logic [7:0] tmp;
        int r;
        for (int x = 0; x < 256; x++) smem[x] = (x < n) ? 8'(x) : 8'h00;
        if (!ident) begin
            for (int x = n - 1; x > 0; x--) begin
                r = int'($urandom_range(x, 0));
                tmp = smem[x]; smem[x] = smem[r]; smem[r] = tmp;
            end
        end
    endtask

    task automatic applyStimulus(input int dut, input bit m, input int len, input bit ident);
        int  n, drop, cyc, mism;
        bit  seen;
        sel  = dut;
        n    = (dut == 2) ? 16 : 256;
        drop = (dut == 1) ? 1 : 0;
        loadS(n, ident);
        ctmem[0] = 8'(len);
        refModel(n, drop, len, m);
        ptq.delete();
        s_wr_cnt = 0;
        dual_wr  = 0;
        hi_or    = 4'h0;
        @(negedge clk);
        checkOutput($sformatf("rdy_idle_d%0d", dut), 32'(rdy_m), 32'd1);
        mode = m;
        en_v[dut] = 1'b1;
        @(posedge clk);
        #1;
        en_v = 3'b000;
        mode = ~m;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 3) en_v[dut] = 1'b1;
            if (cyc == 4) en_v[dut] = 1'b0;
            if (done_m) seen = 1'b1;
        end
        checkOutput($sformatf("done_seen_d%0d", dut), 32'(seen), 32'd1);
        checkOutput($sformatf("latency_d%0d_len%0d", dut, len), 32'(cyc), 32'(2 + 6 * (drop + len)));
        @(posedge clk);
        #1;
        checkOutput("done_pulse", 32'(done_m), 32'd0);
        checkOutput("rdy_after_done", 32'(rdy_m), 32'd1);
        checkOutput("pt_write_count", 32'(ptq.size()), 32'(len + 1));
        for (int x = 0; x < ptq.size() && x <= len; x++)
            checkOutput($sformatf("pt_d%0d_k%0d", dut, x), 32'(ptq[x]), {16'h0, 8'(x), pt_exp[x]});
        mism = 0;
        for (int x = 0; x < n; x++) if (int'(smem[x]) != s_ref[x]) mism++;
        checkOutput("s_final_mismatches", 32'(mism), 32'd0);
        checkOutput("s_write_count", 32'(s_wr_cnt), 32'(2 * (drop + len)));
        checkOutput("dual_write", 32'(dual_wr), 32'd0);
        if (dut == 2 && m) checkOutput("pt_hi_nibble", 32'(hi_or), 32'd0);
    endtask

    task automatic resetMidRun();
        int  cyc;
        bit  seen;
        sel = 0;
        loadS(256, 1'b0);
        fillCt();
        ctmem[0] = 8'd10;
        @(negedge clk);
        mode = 1'b0;
        en_v[0] = 1'b1;
        @(posedge clk);
        #1;
        en_v = 3'b000;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
            if (s_wren_m) seen = 1'b1;
        end
        checkOutput("rst_first_swren_seen", 32'(seen), 32'd1);
        checkOutput("rst_first_swren_cycle", 32'(cyc), 32'd4);
        rst = 1'b1;
        #1;
        checkOutput("rst_swren_gated", 32'(s_wren_m), 32'd0);
        checkOutput("rst_ptwren_gated", 32'(pt_wren_m), 32'd0);
        s_wr_cnt = 0;
        ptq.delete();
        @(posedge clk);
        #1;
        checkOutput("rst_rdy_low", 32'(rdy_m), 32'd0);
        checkOutput("rst_done_low", 32'(done_m), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rdy_after_midrun_rst", 32'(rdy_m), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("rst_no_s_writes", 32'(s_wr_cnt), 32'd0);
        checkOutput("rst_no_pt_writes", 32'(ptq.size()), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        en_v     = 3'b000;
        mode     = 1'b0;
        sel      = 0;
        s_wr_cnt = 0;
        dual_wr  = 0;
        hi_or    = 4'h0;
        for (int x = 0; x < 256; x++) begin
            smem[x] = 8'h00; ctmem[x] = 8'h00; ptmem[x] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rdy", 32'(rdy_m), 32'd0);
        checkOutput("reset_done", 32'(done_m), 32'd0);
        checkOutput("reset_swren", 32'(s_wren_m), 32'd0);
        checkOutput("reset_ptwren", 32'(pt_wren_m), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rdy_after_reset", 32'(rdy_m), 32'd1);

        fillCt();
        applyStimulus(0, 1'b1, 2, 1'b1);
        checkOutput("t1_pt0", 32'(ptmem[0]), 32'h02);
        checkOutput("t1_pt1", 32'(ptmem[1]), 32'h02);
        checkOutput("t1_pt2", 32'(ptmem[2]), 32'h05);
        checkOutput("t1_s2", 32'(smem[2]), 32'h03);
        checkOutput("t1_s3", 32'(smem[3]), 32'h02);

        ctmem[1] = 8'hFF;
        ctmem[2] = 8'h0F;
        applyStimulus(0, 1'b0, 2, 1'b1);
        checkOutput("t2_pt1", 32'(ptmem[1]), 32'hFD);
        checkOutput("t2_pt2", 32'(ptmem[2]), 32'h0A);

        applyStimulus(1, 1'b1, 1, 1'b1);
        checkOutput("t3_drop_pt1", 32'(ptmem[1]), 32'h05);

        applyStimulus(2, 1'b1, 20, 1'b1);
        applyStimulus(0, 1'b1, 0, 1'b1);

        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 3; d++) begin
                fillCt();
                applyStimulus(d, 1'($urandom_range(1, 0)),
                              (d == 2) ? int'($urandom_range(40, 1)) : int'($urandom_range(255, 1)),
                              1'b0);
            end
        end

        resetMidRun();
        fillCt();
        applyStimulus(0, 1'b0, 7, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
